// File: rtl/gray_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter_if
//  Description : Control/status bundle for gray_counter.
//                master : drives clr, load, load_val, en, up; observes outputs
//                slave  : the counter itself; drives bin_o, gray_o, wrap_o,
//                         gray_err_o
//  Signals     : clr        synchronous clear to binary 0
//                load       synchronous load of load_val
//                load_val   WIDTH-bit binary value to load
//                en         count enable
//                up         1 = increment, 0 = decrement
//                bin_o      registered binary count
//                gray_o     registered reflected Gray code of bin_o
//                wrap_o     one-cycle pulse, previous update wrapped
//                gray_err_o sticky Gray single-step violation flag
//  Revision    : 1.0 - initial release
// ============================================================================
interface gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] bin_o;
    logic [WIDTH-1:0] gray_o;
    logic             wrap_o;
    logic             gray_err_o;

    modport master (
        output clr,
        output load,
        output load_val,
        output en,
        output up,
        input  bin_o,
        input  gray_o,
        input  wrap_o,
        input  gray_err_o
    );

    modport slave (
        input  clr,
        input  load,
        input  load_val,
        input  en,
        input  up,
        output bin_o,
        output gray_o,
        output wrap_o,
        output gray_err_o
    );
endinterface
`default_nettype wire

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter
//  Description : Registered up/down binary counter presenting its value in
//                both binary and reflected Gray code (gray = bin ^ bin>>1).
//                Used as a CDC FIFO pointer generator: the Gray value is
//                registered so only one bit changes per count step and no
//                combinational glitch reaches the crossing.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                bus    gray_counter_if.slave (clr, load, load_val, en, up,
//                       bin_o, gray_o, wrap_o, gray_err_o)
//  Parameters  : WIDTH     counter width, 2..32
//                RESET_VAL binary value loaded on reset, < 2**WIDTH
//  Options     : GRAY_CNT_CHECK_EN - when defined, a registered checker
//                flags (sticky until rst_n or clr) any en-only update whose
//                Gray output did not change by exactly one bit. When not
//                defined gray_err_o is tied low and no checker is built.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_counter #(
    parameter int          WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    gray_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] c_reset_bin  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] c_reset_gray = c_reset_bin ^ (c_reset_bin >> 1);
    localparam logic [WIDTH-1:0] c_max        = '1;
    localparam logic [WIDTH-1:0] c_one        = WIDTH'(1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_wrap_next;

    // ------------------------------------------------------------------
    // Next-state selection, priority clr > load > en
    // ------------------------------------------------------------------
    always_comb begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        if (bus.clr) begin
            w_bin_next = '0;
        end else if (bus.load) begin
            w_bin_next = bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                w_bin_next  = r_bin + c_one;
                w_wrap_next = (r_bin == c_max);
            end else begin
                w_bin_next  = r_bin - c_one;
                w_wrap_next = (r_bin == '0);
            end
        end
    end

    // Gray is derived from the next binary value so both registers update
    // on the same edge and are always mutually consistent.
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= c_reset_bin;
            r_gray <= c_reset_gray;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign bus.bin_o  = r_bin;
    assign bus.gray_o = r_gray;
    assign bus.wrap_o = r_wrap;

`ifdef GRAY_CNT_CHECK_EN
    // ------------------------------------------------------------------
    // Single-step checker: remember the Gray value that preceded an
    // en-only update, then on the following cycle compare it with the
    // value actually presented on gray_o.
    // ------------------------------------------------------------------
    logic             w_en_only;
    logic [WIDTH-1:0] w_gray_diff;
    logic             w_single_bit;
    logic             r_chk_pending;
    logic [WIDTH-1:0] r_gray_prev;
    logic             r_gray_err;

    assign w_en_only   = !bus.clr && !bus.load && bus.en;
    assign w_gray_diff = r_gray_prev ^ r_gray;
    // Exactly one bit set: non-zero and a power of two.
    assign w_single_bit = (w_gray_diff != '0) &&
                          ((w_gray_diff & (w_gray_diff - c_one)) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_pending <= 1'b0;
            r_gray_prev   <= c_reset_gray;
            r_gray_err    <= 1'b0;
        end else begin
            r_chk_pending <= w_en_only;
            r_gray_prev   <= r_gray;
            if (bus.clr) begin
                r_gray_err <= 1'b0;
            end else if (r_chk_pending && !w_single_bit) begin
                r_gray_err <= 1'b1;
            end
        end
    end

    assign bus.gray_err_o = r_gray_err;
`else
    assign bus.gray_err_o = 1'b0;
`endif

endmodule
`default_nettype wire
